uart_tx_cts: RTL and testbench

UART_TX_CTS -- requirements
Module: uart_tx_cts

---
 rtl/uart_tx_cts.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_tx_cts.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cts.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cts
// Description : FIFO-buffered UART transmitter with CTS flow control, 8N1 by
//               default; define UART_TX_PARITY_EN for 8E1 framing.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cts #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                        clk_100mhz,
    input  logic                        reset,
    input  logic [7:0]                  s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        uart_txd,
    input  logic                        uart_ctsn,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int                CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int                BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int                AW           = $clog2(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST    = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]       FIFO_FULL    = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              ready_en_q;
    logic              push;
    logic              pop;
    logic [7:0]        head_byte;

    // CTS synchronizer
    logic              cts_meta_q;
    logic              cts_sync_q;
    logic              cts_ok;

    // Transmit engine
    state_t            state_q, state_d;
    logic              txd_q, txd_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              baud_end;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign cts_ok     = ~cts_sync_q;
    assign s_ready    = ready_en_q && (count_q < FIFO_FULL);
    assign push       = s_valid && s_ready;
    assign head_byte  = mem_q[rd_ptr_q];
    assign baud_end   = (baud_q == BAUD_LAST);
    assign uart_txd   = txd_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        txd_d    = txd_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                // The start bit goes out on the same edge the head byte is popped
                if ((count_q != '0) && cts_ok) begin
                    pop      = 1'b1;
                    shift_d  = head_byte;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head_byte;
`endif
                    txd_d    = 1'b0;
                    baud_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    txd_d   = 1'b1;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    txd_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                txd_d   = 1'b1;
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state_q    <= IDLE;
            txd_q      <= 1'b1;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            txd_q      <= txd_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_en_q <= 1'b1;
            cts_meta_q <= uart_ctsn;
            cts_sync_q <= cts_meta_q;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk_100mhz) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cts.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cts
// Description : Self-checking bench for uart_tx_cts; frames on the line are
//               decoded and compared against a queue of accepted bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cts;

    localparam int CLK_HZ    = 1000000;
    localparam int BAUD_RATE = 100000;
    localparam int CPB       = CLK_HZ / BAUD_RATE;
    localparam int DEPTH     = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic [7:0] s_data    = 8'h00;
    logic       s_valid   = 1'b0;
    logic       uart_ctsn = 1'b0;
    logic       s_ready;
    logic       uart_txd;
    logic       busy;
    logic [4:0] fifo_count;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] model_q[$];

    always #5 clk = ~clk;

    uart_tx_cts #(
        .CLK_FREQ_HZ(CLK_HZ),
        .BAUD       (BAUD_RATE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_100mhz(clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .uart_txd  (uart_txd),
        .uart_ctsn (uart_ctsn),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    // Line image of a byte, index 0 transmitted first
    function automatic logic [NBITS-1:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, output bit acc);
        s_data  = b;
        s_valid = 1'b1;
        acc     = s_ready;
        tick();
        s_valid = 1'b0;
        if (acc) model_q.push_back(b);
    endtask

    task automatic wait_start(input int maxc, output int waited, output bit found);
        waited = 0;
        found  = 1'b0;
        while (!found && waited < maxc) begin
            tick();
            waited++;
            if (uart_txd === 1'b0) found = 1'b1;
        end
    endtask

    // Called with the first start-bit sample already taken
    task automatic read_frame(output logic [NBITS-1:0] bits, output int unstable);
        int idx;
        bits     = '0;
        unstable = 0;
        bits[0]  = uart_txd;
        for (int c = 1; c < NBITS * CPB; c++) begin
            tick();
            idx = c / CPB;
            if (c % CPB == 0) bits[idx] = uart_txd;
            else if (uart_txd !== bits[idx]) unstable++;
        end
    endtask

    task automatic observe_frame(input int maxw, output bit found, output int waited,
                                 output logic [NBITS-1:0] bits, output int unst,
                                 output logic [NBITS-1:0] expv);
        wait_start(maxw, waited, found);
        bits = '1;
        unst = 0;
        expv = '0;
        if (found) begin
            read_frame(bits, unst);
            if (model_q.size() > 0) expv = frame_of(model_q.pop_front());
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        s_valid   = 1'b0;
        uart_ctsn = 1'b0;
        repeat (3) tick();
        vectors++;
        if (uart_txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd: got %b want 1", uart_txd); end
        vectors++;
        if (s_ready !== 1'b0) begin miscompares++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++;
        if (fifo_count !== 5'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        reset = 1'b0;
        model_q.delete();
        tick();
        vectors++;
        if (s_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset: got %b want 1", s_ready); end
        repeat (2) tick();
    endtask

    task automatic test_single(input logic [7:0] b);
        bit               acc;
        bit               found;
        int               waited;
        int               unst;
        logic [NBITS-1:0] bits;
        logic [NBITS-1:0] expv;
        push_byte(b, acc);
        vectors++;
        if (acc !== 1'b1) begin miscompares++; $display("FAIL single_accept %h: got %b want 1", b, acc); end
        vectors++;
        if (fifo_count !== 5'(model_q.size())) begin
            miscompares++; $display("FAIL single_count %h: got %0d want %0d", b, fifo_count, model_q.size());
        end
        observe_frame(5, found, waited, bits, unst, expv);
        vectors++;
        if (!found || waited != 1) begin
            miscompares++; $display("FAIL single_latency %h: got found=%b cycles=%0d want cycles=1", b, found, waited);
        end
        vectors++;
        if (bits !== expv) begin miscompares++; $display("FAIL single_frame %h: got %b want %b", b, bits, expv); end
        vectors++;
        if (unst != 0) begin miscompares++; $display("FAIL single_bit_width %h: got %0d glitches want 0", b, unst); end
        tick();
        vectors++;
        if (busy !== 1'b0 || uart_txd !== 1'b1) begin
            miscompares++; $display("FAIL single_idle %h: got busy=%b txd=%b want busy=0 txd=1", b, busy, uart_txd);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) test_single(8'($urandom_range(0, 255)));
    endtask

    task automatic test_cts_hold();
        bit               acc;
        bit               found;
        int               waited;
        int               unst;
        int               bad;
        logic [NBITS-1:0] bits;
        logic [NBITS-1:0] expv;
        uart_ctsn = 1'b1;
        repeat (4) tick();
        push_byte(8'hA3, acc);
        bad = 0;
        repeat (20) begin
            tick();
            if (uart_txd !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL cts_hold_line: got %0d low samples want 0", bad); end
        vectors++;
        if (fifo_count !== 5'd1) begin miscompares++; $display("FAIL cts_hold_count: got %0d want 1", fifo_count); end
        uart_ctsn = 1'b0;
        observe_frame(6, found, waited, bits, unst, expv);
        vectors++;
        if (!found || waited > 3) begin
            miscompares++; $display("FAIL cts_release_latency: got found=%b cycles=%0d want <=3", found, waited);
        end
        vectors++;
        if (bits !== expv || unst != 0) begin
            miscompares++; $display("FAIL cts_frame: got %b (glitches %0d) want %b", bits, unst, expv);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit               acc;
        bit               found;
        int               waited;
        int               unst;
        logic [NBITS-1:0] bits;
        logic [NBITS-1:0] expv;
        uart_ctsn = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < DEPTH + 1; i++) begin
            s_data  = 8'($urandom_range(0, 255));
            s_valid = 1'b1;
            vectors++;
            if (s_ready !== (model_q.size() < DEPTH)) begin
                miscompares++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, s_ready, model_q.size() < DEPTH);
            end
            vectors++;
            if (fifo_count !== 5'(model_q.size())) begin
                miscompares++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, fifo_count, model_q.size());
            end
            acc = s_ready;
            tick();
            if (acc) model_q.push_back(s_data);
        end
        s_valid = 1'b0;
        vectors++;
        if (fifo_count !== 5'(DEPTH) || s_ready !== 1'b0) begin
            miscompares++; $display("FAIL b2b_full: got count=%0d ready=%b want count=%0d ready=0", fifo_count, s_ready, DEPTH);
        end
        uart_ctsn = 1'b0;
        for (int f = 0; f < DEPTH; f++) begin
            observe_frame((f == 0) ? 6 : 4, found, waited, bits, unst, expv);
            vectors++;
            if (!found || waited > ((f == 0) ? 3 : 2)) begin
                miscompares++; $display("FAIL b2b_gap[%0d]: got found=%b cycles=%0d", f, found, waited);
            end
            vectors++;
            if (bits !== expv || unst != 0) begin
                miscompares++; $display("FAIL b2b_frame[%0d]: got %b (glitches %0d) want %b", f, bits, unst, expv);
            end
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || fifo_count !== 5'd0) begin
            miscompares++; $display("FAIL b2b_drain: got busy=%b count=%0d want 0/0", busy, fifo_count);
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        bit found;
        int waited;
        int bad;
        uart_ctsn = 1'b1;
        repeat (4) tick();
        push_byte(8'hFF, acc);
        push_byte(8'h5A, acc);
        uart_ctsn = 1'b0;
        wait_start(6, waited, found);
        vectors++;
        if (!found) begin miscompares++; $display("FAIL rstmid_start: got no start want start"); end
        // Middle of data bit 3 (line bit index 4)
        repeat (4 * CPB + CPB / 2) tick();
        vectors++;
        if (fifo_count !== 5'd1) begin miscompares++; $display("FAIL rstmid_queued: got %0d want 1", fifo_count); end
        reset = 1'b1;
        tick();
        vectors++;
        if (uart_txd !== 1'b1 || fifo_count !== 5'd0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_state: got txd=%b count=%0d busy=%b want 1/0/0", uart_txd, fifo_count, busy);
        end
        reset = 1'b0;
        model_q.delete();
        bad = 0;
        repeat (2 * NBITS * CPB) begin
            tick();
            if (uart_txd !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_quiet: got %0d low samples busy=%b want 0/0", bad, busy);
        end
    endtask

    task automatic test_cts_midframe();
        bit               acc;
        bit               found;
        int               waited;
        int               unst;
        int               bad;
        logic [NBITS-1:0] bits;
        logic [NBITS-1:0] expv;
        uart_ctsn = 1'b1;
        repeat (4) tick();
        push_byte(8'h12, acc);
        push_byte(8'h34, acc);
        uart_ctsn = 1'b0;
        wait_start(6, waited, found);
        uart_ctsn = 1'b1;
        vectors++;
        if (!found) begin miscompares++; $display("FAIL midcts_start: got no start want start"); end
        expv = '0;
        bits = '1;
        unst = 0;
        if (found) begin
            read_frame(bits, unst);
            expv = frame_of(model_q.pop_front());
        end
        vectors++;
        if (bits !== expv || unst != 0) begin
            miscompares++; $display("FAIL midcts_frame: got %b (glitches %0d) want %b", bits, unst, expv);
        end
        bad = 0;
        repeat (4 * CPB) begin
            tick();
            if (uart_txd !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0 || fifo_count !== 5'd1) begin
            miscompares++; $display("FAIL midcts_hold: got %0d low samples count=%0d want 0/1", bad, fifo_count);
        end
        uart_ctsn = 1'b0;
        observe_frame(6, found, waited, bits, unst, expv);
        vectors++;
        if (!found || waited > 3 || bits !== expv || unst != 0) begin
            miscompares++; $display("FAIL midcts_second: got found=%b cycles=%0d bits=%b want %b", found, waited, bits, expv);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single(8'h55);
        test_single(8'h07);
        test_single(8'h03);
        test_random();
        test_cts_hold();
        test_back_to_back();
        test_reset_mid();
        test_cts_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
